// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage.
// Holds the default widths, the zero-register index and the FSM state type.
package operand_fetch_stage_pkg;

    localparam int OFS_DATA_W = 64;
    localparam int OFS_ADDR_W = 6;
    localparam int OFS_XZR    = 31;

    // EMPTY: no operands presented to execute; FULL: operands held on out_*.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ofs_state_e;

endpackage

// File: rtl/operand_fetch_stage_operand_mux.sv
// Single-source operand resolution for the operand fetch stage.
// Priority: zero register, then EX, MEM, WB producers (youngest first), then
// the register-bank read data. Producer enables arrive already qualified.
module ofs_operand_mux
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = OFS_DATA_W,
    parameter int ADDR_W = OFS_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_src,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_ex_fwd,
    input  logic [ADDR_W-1:0] i_ex_rd,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic              i_mem_fwd,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_wb_fwd,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data
);

    // Pick the youngest matching producer; the zero register never forwards.
    always_comb begin
        o_data = i_rf_data;
        if (i_src == ADDR_W'(OFS_XZR)) begin
            o_data = '0;
        end else if (i_ex_fwd && (i_ex_rd == i_src)) begin
            o_data = i_ex_result;
        end else if (i_mem_fwd && (i_mem_rd == i_src)) begin
            o_data = i_mem_result;
        end else if (i_wb_fwd && (i_wb_rd == i_src)) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-bank reads, resolves both sources with
// forwarding and the zero register, stalls on hazards, and registers the
// operands toward execute over valid/ready.
// Build option: define OFS_FORWARDING_EN to enable EX/MEM forwarding; when it
// is undefined only the WB bypass remains and any EX/MEM producer stalls.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds its payload stable while valid is high and ready low.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = OFS_DATA_W,
    parameter int ADDR_W = OFS_ADDR_W,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rn,
    input  logic [ADDR_W-1:0] in_rm,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              ex_valid,
    input  logic              ex_wr,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_wr,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output ofs_state_e        dbg_state
);

    ofs_state_e          r_state;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_a, r_b, r_imm;
    logic [ADDR_W-1:0]   r_rd;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_ex_alu, w_ex_load, w_mem_wr;
    logic                w_ex_src_hit;
    logic                w_ex_fwd, w_mem_fwd;
    logic                w_hazard, w_adv, w_xfer;
    logic [DATA_W-1:0]   w_a, w_b;

    assign rf_addr_a = in_rn;
    assign rf_addr_b = in_rm;

    assign w_ex_alu     = ex_valid & ex_wr & ~ex_is_load;
    assign w_ex_load    = ex_valid & ex_wr & ex_is_load;
    assign w_mem_wr     = mem_valid & mem_wr;
    assign w_ex_src_hit = (ex_rd != ADDR_W'(OFS_XZR)) & ((ex_rd == in_rn) | (ex_rd == in_rm));

`ifdef OFS_FORWARDING_EN
    // Only a load in EX cannot supply its value yet.
    assign w_ex_fwd  = w_ex_alu;
    assign w_mem_fwd = w_mem_wr;
    assign w_hazard  = in_valid & w_ex_load & w_ex_src_hit;
`else
    // No EX/MEM paths: any in-flight writer of a source (load or ALU) stalls.
    logic w_mem_src_hit;
    assign w_mem_src_hit = (mem_rd != ADDR_W'(OFS_XZR)) & ((mem_rd == in_rn) | (mem_rd == in_rm));
    assign w_ex_fwd  = 1'b0;
    assign w_mem_fwd = 1'b0;
    assign w_hazard  = in_valid & (((w_ex_alu | w_ex_load) & w_ex_src_hit) | (w_mem_wr & w_mem_src_hit));
`endif

    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv & ~w_hazard;
    assign w_xfer   = w_adv & in_valid & ~w_hazard;

    ofs_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
        .i_src(in_rn), .i_rf_data(rf_data_a),
        .i_ex_fwd(w_ex_fwd), .i_ex_rd(ex_rd), .i_ex_result(ex_result),
        .i_mem_fwd(w_mem_fwd), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
        .i_wb_fwd(wb_wr), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_data(w_a)
    );

    ofs_operand_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
        .i_src(in_rm), .i_rf_data(rf_data_b),
        .i_ex_fwd(w_ex_fwd), .i_ex_rd(ex_rd), .i_ex_result(ex_result),
        .i_mem_fwd(w_mem_fwd), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
        .i_wb_fwd(wb_wr), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_data(w_b)
    );

    // EMPTY/FULL output register: load on transfer, drop valid on bubble, hold when blocked.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_ctrl      <= '0;
        end else if (w_adv) begin
            if (w_xfer) begin
                r_state     <= ST_FULL;
                r_out_valid <= 1'b1;
                r_a         <= w_a;
                r_b         <= w_b;
                r_imm       <= in_imm;
                r_rd        <= in_rd;
                r_ctrl      <= in_ctrl;
            end else begin
                r_state     <= ST_EMPTY;
                r_out_valid <= 1'b0;
            end
        end
    end

    // Saturating count of cycles an offered instruction is held back by a hazard.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_imm   = r_imm;
    assign out_rd    = r_rd;
    assign out_ctrl  = r_ctrl;
    assign stall_cnt = r_stall_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the stage.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 32;
`ifdef OFS_FORWARDING_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [ADDR_W-1:0] in_rn, in_rm, in_rd;
    logic [DATA_W-1:0] in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [ADDR_W-1:0] rf_addr_a, rf_addr_b;
    logic [DATA_W-1:0] rf_data_a, rf_data_b;
    logic              ex_valid, ex_wr, ex_is_load;
    logic [ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic              mem_valid, mem_wr;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic              wb_wr;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_a, out_b, out_imm;
    logic [ADDR_W-1:0] out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    ofs_state_e        dbg_state;

    // Clock / reset block
    always #5 clock = ~clock;

    operand_fetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .out_rd(out_rd), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: expected out_a of each accepted instruction, in order.
    logic [DATA_W-1:0] exp_q[$];

    // Behavioural model of what execute should see.
    logic              m_valid;
    logic [DATA_W-1:0] m_a, m_b, m_imm;
    logic [ADDR_W-1:0] m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    logic [CNT_W-1:0]  m_stall;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Value a source register holds as seen by an instruction in fetch.
    function automatic logic [DATA_W-1:0] ref_operand(input logic [ADDR_W-1:0] src,
                                                     input logic [DATA_W-1:0] rf);
        logic              hit  [3];
        logic [ADDR_W-1:0] prd  [3];
        logic [DATA_W-1:0] pdat [3];
        logic [DATA_W-1:0] val;
        logic              found;
        hit[0] = (FWD == 1) && ex_valid && ex_wr && !ex_is_load;
        hit[1] = (FWD == 1) && mem_valid && mem_wr;
        hit[2] = wb_wr;
        prd[0] = ex_rd;  prd[1] = mem_rd;  prd[2] = wb_rd;
        pdat[0] = ex_result; pdat[1] = mem_result; pdat[2] = wb_data;
        val = rf;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && hit[i] && prd[i] == src) begin
                val = pdat[i];
                found = 1'b1;
            end
        end
        if (src == 31) val = '0;
        return val;
    endfunction

    // Whether the offered instruction must wait because a source is not yet available.
    function automatic logic ref_hazard();
        logic              blocks;
        logic              pw  [2];
        logic [ADDR_W-1:0] prd [2];
        blocks = 1'b0;
        if (FWD == 1) begin
            pw[0] = ex_valid && ex_wr && ex_is_load;
            pw[1] = 1'b0;
        end else begin
            pw[0] = ex_valid && ex_wr;
            pw[1] = mem_valid && mem_wr;
        end
        prd[0] = ex_rd; prd[1] = mem_rd;
        for (int i = 0; i < 2; i++)
            if (pw[i] && prd[i] != 31 && (prd[i] == in_rn || prd[i] == in_rm)) blocks = 1'b1;
        return in_valid && blocks;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0; m_stall = '0;
        exp_q.delete();
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic              hz, exp_ready;
        logic [DATA_W-1:0] a_v, b_v, head;
        #1;
        hz = ref_hazard();
        exp_ready = (!m_valid || out_ready) && !hz;
        check("in_ready", in_ready, exp_ready);
        check("rf_addr_a", rf_addr_a, in_rn);
        check("rf_addr_b", rf_addr_b, in_rm);
        if (!reset && m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $error("FAIL consumed observed=%0h expected=<none>", out_a);
            end else begin
                head = exp_q.pop_front();
                check("consumed_a", out_a, head);
            end
        end
        a_v = ref_operand(in_rn, rf_data_a);
        b_v = ref_operand(in_rm, rf_data_b);
        if (reset) begin
            model_clear();
        end else begin
            if (hz && m_stall != '1) m_stall = m_stall + 1;
            if (!m_valid || out_ready) begin
                if (in_valid && !hz) begin
                    m_valid = 1'b1; m_a = a_v; m_b = b_v;
                    m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
                    exp_q.push_back(a_v);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_a", out_a, m_a);
        check("out_b", out_b, m_b);
        check("out_imm", out_imm, m_imm);
        check("out_rd", out_rd, m_rd);
        check("out_ctrl", out_ctrl, m_ctrl);
        check("stall_cnt", stall_cnt, m_stall);
        check("state", 64'(dbg_state == ST_FULL), 64'(m_valid));
    endtask

    // Driver: quiet pipeline, execute always ready.
    task automatic set_idle();
        in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0;
        in_imm = {$urandom, $urandom}; in_ctrl = CTRL_W'($urandom);
        rf_data_a = {$urandom, $urandom}; rf_data_b = {$urandom, $urandom};
        ex_valid = 0; ex_wr = 0; ex_is_load = 0; ex_rd = 0; ex_result = '0;
        mem_valid = 0; mem_wr = 0; mem_rd = 0; mem_result = '0;
        wb_wr = 0; wb_rd = 0; wb_data = '0;
        out_ready = 1;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_reg();
        int r;
        r = $urandom_range(0, 7);
        return (r > 5) ? ADDR_W'(31) : ADDR_W'(r);
    endfunction

    initial begin
        logic [CNT_W-1:0] s0;

        // Reset
        set_idle();
        reset = 1;
        model_clear();
        @(posedge clock);
        cycle();
        reset = 0;

        // Idle after reset
        cycle();
        check("idle_stall_cnt", stall_cnt, 0);

        // ALU result in EX feeding source A
        s0 = m_stall;
        set_idle();
        in_valid = 1; in_rn = 3; in_rm = 0; in_rd = 7; rf_data_a = 5;
        ex_valid = 1; ex_wr = 1; ex_rd = 3; ex_result = 9;
        cycle();
        ex_valid = 0; wb_wr = 1; wb_rd = 3; wb_data = 9;
        cycle();
        check("ex_fwd_a", out_a, 9);
        check("ex_fwd_stalls", stall_cnt, s0 + ((FWD == 1) ? 0 : 1));

        // Load in EX feeding source B
        s0 = m_stall;
        set_idle();
        in_valid = 1; in_rn = 1; in_rm = 4; in_rd = 8; rf_data_b = 64'h55;
        ex_valid = 1; ex_wr = 1; ex_is_load = 1; ex_rd = 4; ex_result = 64'hDEAD;
        cycle();
        ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_wr = 1; mem_rd = 4; mem_result = 64'h1234;
        cycle();
        mem_valid = 0; wb_wr = 1; wb_rd = 4; wb_data = 64'h1234;
        cycle();
        check("load_use_b", out_b, 64'h1234);
        check("load_use_stalls", stall_cnt, s0 + ((FWD == 1) ? 1 : 2));

        // Zero register never forwards
        set_idle();
        in_valid = 1; in_rn = 31; in_rm = 2; rf_data_a = 64'hFF;
        ex_valid = 1; ex_wr = 1; ex_rd = 31; ex_result = 7;
        mem_valid = 1; mem_wr = 1; mem_rd = 31; mem_result = 8;
        wb_wr = 1; wb_rd = 31; wb_data = 9;
        cycle();
        check("xzr_a", out_a, 0);

        // WB bypass ahead of the bank write
        set_idle();
        in_valid = 1; in_rn = 2; in_rm = 5; rf_data_a = 64'h11;
        wb_wr = 1; wb_rd = 2; wb_data = 64'hAA;
        cycle();
        check("wb_bypass_a", out_a, 64'hAA);

        // Backpressure: hold for three cycles, then release
        set_idle();
        in_valid = 1; in_rn = 6; in_rm = 7; in_rd = 9; rf_data_a = 64'h100;
        cycle();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_rn = ADDR_W'(10 + i); rf_data_a = 64'h200 + 64'(i); in_imm = 64'(i);
            cycle();
            check("hold_a", out_a, 64'h100);
        end
        out_ready = 1;
        cycle();
        check("release_accept", out_a, 64'h202);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_rn = rnd_reg(); in_rm = rnd_reg(); in_rd = rnd_reg();
            in_imm = {$urandom, $urandom}; in_ctrl = CTRL_W'($urandom);
            rf_data_a = {$urandom, $urandom}; rf_data_b = {$urandom, $urandom};
            ex_valid = $urandom_range(0, 1); ex_wr = $urandom_range(0, 1);
            ex_is_load = $urandom_range(0, 1); ex_rd = rnd_reg(); ex_result = {$urandom, $urandom};
            mem_valid = $urandom_range(0, 1); mem_wr = $urandom_range(0, 1);
            mem_rd = rnd_reg(); mem_result = {$urandom, $urandom};
            wb_wr = $urandom_range(0, 1); wb_rd = rnd_reg(); wb_data = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 0;

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
